// File: rtl/mst_wr_arbiter.sv
// Round-robin arbiter sharing one master write port between NM requesters.
// Optional watchdog release enabled by defining MST_WR_ARB_TIMEOUT_EN.
module mst_wr_arbiter #(
  parameter int NM     = 4,
  parameter int AW     = 12,
  parameter int DW     = 32,
  parameter int SW     = 4,
  parameter int TO_CYC = 256
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic [NM-1:0]    iReqWrReq,
  input  logic [NM-1:0]    iReqWrValid,
  input  logic [NM*AW-1:0] iReqWrAddr,
  input  logic [NM*SW-1:0] iReqWrSel,
  input  logic [NM-1:0]    iReqWrLast,
  input  logic [NM*DW-1:0] iReqWrData,
  output logic [NM-1:0]    oReqWrReady,
  output logic [NM-1:0]    oGrant,
  output logic             oMstWrReq,
  output logic             oMstWrValid,
  output logic [AW-1:0]    oMstWrAddr,
  output logic [SW-1:0]    oMstWrSel,
  output logic             oMstWrLast,
  output logic [DW-1:0]    oMstWrData,
  input  logic             iMstWrReady,
  output logic             oArbTimeout
);

  localparam int PW = (NM > 1) ? $clog2(NM) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_gidx;
  logic [NM-1:0]   r_grant;
  logic [PW-1:0]   w_pick;
  logic            w_any;
  logic            w_req;
  logic            w_valid;
  logic            w_last;
  logic [AW-1:0]   w_addr;
  logic [SW-1:0]   w_sel;
  logic [DW-1:0]   w_data;
  logic            w_active;
  logic            w_acc;
  logic            w_to;

  // Round-robin search starting at r_ptr; lowest offset wins.
  always_comb begin
    int j;
    j      = 0;
    w_any  = 1'b0;
    w_pick = r_ptr;
    for (int i = NM - 1; i >= 0; i--) begin
      j = int'(r_ptr) + i;
      if (j >= NM) begin
        j = j - NM;
      end else begin
        j = j;
      end
      if (iReqWrReq[j]) begin
        w_any  = 1'b1;
        w_pick = PW'(j);
      end else begin
        w_any  = w_any;
      end
    end
  end

  // Select the granted requester's lanes.
  always_comb begin
    w_req   = iReqWrReq[r_gidx];
    w_valid = iReqWrValid[r_gidx];
    w_last  = iReqWrLast[r_gidx];
    w_addr  = iReqWrAddr[int'(r_gidx)*AW +: AW];
    w_sel   = iReqWrSel[int'(r_gidx)*SW +: SW];
    w_data  = iReqWrData[int'(r_gidx)*DW +: DW];
  end

  // Port only drives while busy and the owner still requests; an abort blanks it at once.
  assign w_active = (r_state == ST_BUSY) && w_req;
  assign w_acc    = w_active && w_valid && iMstWrReady;

`ifdef MST_WR_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TO_CYC) + 1;
  logic [CW-1:0] r_to_cnt;
  logic          r_timeout;

  assign w_to = (r_state == ST_BUSY) && (r_to_cnt == CW'(TO_CYC - 1)) && !w_acc;

  // Watchdog counts stalled BUSY cycles; cleared outside BUSY and on every beat.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_to_cnt <= {CW{1'b0}};
    end else if ((r_state != ST_BUSY) || w_acc) begin
      r_to_cnt <= {CW{1'b0}};
    end else begin
      r_to_cnt <= r_to_cnt + CW'(1);
    end
  end

  // Timeout pulse lines up with the forced GAP cycle.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_to;
    end
  end

  assign oArbTimeout = r_timeout;
`else
  assign w_to        = 1'b0;
  assign oArbTimeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_next = ST_BUSY;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (!w_req || (w_acc && w_last) || w_to) begin
          w_next = ST_GAP;
        end else begin
          w_next = ST_BUSY;
        end
      end
      ST_GAP:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Grant, owner index and pointer; pointer moves only when a grant is issued.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_ptr   <= {PW{1'b0}};
      r_gidx  <= {PW{1'b0}};
      r_grant <= {NM{1'b0}};
    end else if ((r_state == ST_IDLE) && w_any) begin
      r_gidx  <= w_pick;
      r_grant <= NM'(1) << w_pick;
      if (int'(w_pick) == NM - 1) begin
        r_ptr <= {PW{1'b0}};
      end else begin
        r_ptr <= w_pick + PW'(1);
      end
    end else if (w_next != ST_BUSY) begin
      r_ptr   <= r_ptr;
      r_gidx  <= r_gidx;
      r_grant <= {NM{1'b0}};
    end else begin
      r_ptr   <= r_ptr;
      r_gidx  <= r_gidx;
      r_grant <= r_grant;
    end
  end

  // Output logic.
  always_comb begin
    oGrant      = r_grant;
    oReqWrReady = {NM{1'b0}};
    oMstWrReq   = 1'b0;
    oMstWrValid = 1'b0;
    oMstWrAddr  = {AW{1'b0}};
    oMstWrSel   = {SW{1'b0}};
    oMstWrLast  = 1'b0;
    oMstWrData  = {DW{1'b0}};
    if (w_active) begin
      oReqWrReady[r_gidx] = iMstWrReady;
      oMstWrReq           = 1'b1;
      oMstWrValid         = w_valid;
      oMstWrAddr          = w_addr;
      oMstWrSel           = w_sel;
      oMstWrLast          = w_last;
      oMstWrData          = w_data;
    end else begin
      oMstWrReq           = 1'b0;
    end
  end

endmodule

// File: tb/tb_mst_wr_arbiter.sv
// Table-driven directed bench for mst_wr_arbiter (NM=4, AW=12, DW=32, SW=4, TO_CYC=16).
module tb_mst_wr_arbiter;

  logic        iClk = 1'b0;
  logic        iRst;
  logic [3:0]  iReqWrReq, iReqWrValid, iReqWrLast;
  logic [47:0] iReqWrAddr;
  logic [15:0] iReqWrSel;
  logic [127:0] iReqWrData;
  logic [3:0]  oReqWrReady, oGrant;
  logic        oMstWrReq, oMstWrValid, oMstWrLast, iMstWrReady, oArbTimeout;
  logic [11:0] oMstWrAddr;
  logic [3:0]  oMstWrSel;
  logic [31:0] oMstWrData;

  int total = 0;
  int bad   = 0;

  mst_wr_arbiter #(.NM(4), .AW(12), .DW(32), .SW(4), .TO_CYC(16)) dut (
    .iClk(iClk), .iRst(iRst),
    .iReqWrReq(iReqWrReq), .iReqWrValid(iReqWrValid), .iReqWrAddr(iReqWrAddr),
    .iReqWrSel(iReqWrSel), .iReqWrLast(iReqWrLast), .iReqWrData(iReqWrData),
    .oReqWrReady(oReqWrReady), .oGrant(oGrant),
    .oMstWrReq(oMstWrReq), .oMstWrValid(oMstWrValid), .oMstWrAddr(oMstWrAddr),
    .oMstWrSel(oMstWrSel), .oMstWrLast(oMstWrLast), .oMstWrData(oMstWrData),
    .iMstWrReady(iMstWrReady), .oArbTimeout(oArbTimeout)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    logic       rst;
    logic [3:0] req, vld, lst;
    logic       rdy;
    int         src;
    logic [11:0] addr;
    logic [3:0] e_gnt;
    logic       e_req, e_vld, e_last;
    logic [3:0] e_rdy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic [3:0] req, input logic [3:0] vld,
                              input logic [3:0] lst, input logic rdy, input int src,
                              input logic [11:0] addr, input logic [3:0] e_gnt,
                              input logic e_req, input logic e_vld, input logic e_last,
                              input logic [3:0] e_rdy);
    vec_t v;
    v.rst = rst; v.req = req; v.vld = vld; v.lst = lst; v.rdy = rdy; v.src = src;
    v.addr = addr; v.e_gnt = e_gnt; v.e_req = e_req; v.e_vld = e_vld;
    v.e_last = e_last; v.e_rdy = e_rdy;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d got=0x%0h want=0x%0h", name, idx, act, exp);
    end
  endtask

  // Owner lane carries the real beat; other lanes carry distinct junk.
  task automatic drive(input vec_t v);
    iRst        = v.rst;
    iReqWrReq   = v.req;
    iReqWrValid = v.vld;
    iReqWrLast  = v.lst;
    iMstWrReady = v.rdy;
    for (int m = 0; m < 4; m++) begin
      iReqWrAddr[m*12 +: 12] = (m == v.src) ? v.addr : (12'hE00 | 12'(m));
      iReqWrSel[m*4 +: 4]    = (m == v.src) ? 4'(v.src + 1) : 4'hA;
      iReqWrData[m*32 +: 32] = (m == v.src) ? {20'hDA7A0, v.addr} : (32'hBAD0_0000 | 32'(m));
    end
  endtask

  initial begin
    logic [3:0] gm;
    int g;
    int pulse_at;

    // Single requester 1, 4-beat INCR burst, then two Req-low cycles.
    vecs.push_back(mk(1'b1, 4'h0, 4'h0, 4'h0, 1'b1, 1, 12'h000, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0));
    vecs.push_back(mk(1'b0, 4'h2, 4'h2, 4'h0, 1'b1, 1, 12'h100, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0));
    vecs.push_back(mk(1'b0, 4'h2, 4'h2, 4'h0, 1'b1, 1, 12'h100, 4'h2, 1'b1, 1'b1, 1'b0, 4'h2));
    vecs.push_back(mk(1'b0, 4'h2, 4'h2, 4'h0, 1'b1, 1, 12'h104, 4'h2, 1'b1, 1'b1, 1'b0, 4'h2));
    vecs.push_back(mk(1'b0, 4'h2, 4'h2, 4'h0, 1'b1, 1, 12'h108, 4'h2, 1'b1, 1'b1, 1'b0, 4'h2));
    vecs.push_back(mk(1'b0, 4'h2, 4'h2, 4'h2, 1'b1, 1, 12'h10C, 4'h2, 1'b1, 1'b1, 1'b1, 4'h2));
    vecs.push_back(mk(1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1, 12'h000, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0));
    vecs.push_back(mk(1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1, 12'h000, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0));

    // All four request continuously with 2-beat bursts: order 0,1,2,3,0,1.
    vecs.push_back(mk(1'b1, 4'hF, 4'hF, 4'h0, 1'b1, 0, 12'h000, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0));
    for (int b = 0; b < 6; b++) begin
      g  = b % 4;
      gm = 4'b0001 << g;
      vecs.push_back(mk(1'b0, 4'hF, 4'hF, 4'h0, 1'b1, g, 12'h000, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0));
      vecs.push_back(mk(1'b0, 4'hF, 4'hF, 4'h0, 1'b1, g, 12'(12'h200 + g*16), gm, 1'b1, 1'b1, 1'b0, gm));
      vecs.push_back(mk(1'b0, 4'hF, 4'hF, gm,   1'b1, g, 12'(12'h204 + g*16), gm, 1'b1, 1'b1, 1'b1, gm));
      vecs.push_back(mk(1'b0, 4'hF, 4'hF, 4'h0, 1'b1, g, 12'h000, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0));
    end

    // Requester 2 stalled 5 cycles mid-burst while requester 3 waits.
    vecs.push_back(mk(1'b1, 4'h0, 4'h0, 4'h0, 1'b1, 2, 12'h000, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0));
    vecs.push_back(mk(1'b0, 4'hC, 4'hC, 4'h0, 1'b1, 2, 12'h300, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0));
    vecs.push_back(mk(1'b0, 4'hC, 4'hC, 4'h0, 1'b1, 2, 12'h300, 4'h4, 1'b1, 1'b1, 1'b0, 4'h4));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(1'b0, 4'hC, 4'hC, 4'h0, 1'b0, 2, 12'h304, 4'h4, 1'b1, 1'b1, 1'b0, 4'h0));
    vecs.push_back(mk(1'b0, 4'hC, 4'hC, 4'h0, 1'b1, 2, 12'h304, 4'h4, 1'b1, 1'b1, 1'b0, 4'h4));
    vecs.push_back(mk(1'b0, 4'hC, 4'hC, 4'h4, 1'b1, 2, 12'h308, 4'h4, 1'b1, 1'b1, 1'b1, 4'h4));
    vecs.push_back(mk(1'b0, 4'h8, 4'h8, 4'h0, 1'b1, 3, 12'h3C0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0));
    vecs.push_back(mk(1'b0, 4'h8, 4'h8, 4'h0, 1'b1, 3, 12'h3C0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0));
    vecs.push_back(mk(1'b0, 4'h8, 4'h8, 4'h8, 1'b1, 3, 12'h3C0, 4'h8, 1'b1, 1'b1, 1'b1, 4'h8));
    vecs.push_back(mk(1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 3, 12'h000, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0));

    // Owner 0 aborts after one beat; requester 1 follows after the gap.
    vecs.push_back(mk(1'b1, 4'h0, 4'h0, 4'h0, 1'b1, 0, 12'h000, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0));
    vecs.push_back(mk(1'b0, 4'h3, 4'h3, 4'h0, 1'b1, 0, 12'h400, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0));
    vecs.push_back(mk(1'b0, 4'h3, 4'h3, 4'h0, 1'b1, 0, 12'h400, 4'h1, 1'b1, 1'b1, 1'b0, 4'h1));
    vecs.push_back(mk(1'b0, 4'h2, 4'h3, 4'h0, 1'b1, 0, 12'h404, 4'h1, 1'b0, 1'b0, 1'b0, 4'h0));
    vecs.push_back(mk(1'b0, 4'h2, 4'h2, 4'h0, 1'b1, 1, 12'h440, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0));
    vecs.push_back(mk(1'b0, 4'h2, 4'h2, 4'h0, 1'b1, 1, 12'h440, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0));
    vecs.push_back(mk(1'b0, 4'h2, 4'h2, 4'h2, 1'b1, 1, 12'h440, 4'h2, 1'b1, 1'b1, 1'b1, 4'h2));
    vecs.push_back(mk(1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1, 12'h000, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0));

    // Reset during beat 2 of requester 1's burst; pointer must restart at 0.
    vecs.push_back(mk(1'b1, 4'h0, 4'h0, 4'h0, 1'b1, 1, 12'h000, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0));
    vecs.push_back(mk(1'b0, 4'h2, 4'h2, 4'h0, 1'b1, 1, 12'h500, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0));
    vecs.push_back(mk(1'b0, 4'h2, 4'h2, 4'h0, 1'b1, 1, 12'h500, 4'h2, 1'b1, 1'b1, 1'b0, 4'h2));
    vecs.push_back(mk(1'b1, 4'h2, 4'h2, 4'h0, 1'b1, 1, 12'h504, 4'h2, 1'b1, 1'b1, 1'b0, 4'h2));
    vecs.push_back(mk(1'b0, 4'hA, 4'hA, 4'h0, 1'b1, 1, 12'h540, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0));
    vecs.push_back(mk(1'b0, 4'hA, 4'hA, 4'h2, 1'b1, 1, 12'h540, 4'h2, 1'b1, 1'b1, 1'b1, 4'h2));
    vecs.push_back(mk(1'b0, 4'h8, 4'h8, 4'h0, 1'b1, 3, 12'h5C0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0));
    vecs.push_back(mk(1'b0, 4'h8, 4'h8, 4'h0, 1'b1, 3, 12'h5C0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0));
    vecs.push_back(mk(1'b0, 4'h8, 4'h8, 4'h8, 1'b1, 3, 12'h5C0, 4'h8, 1'b1, 1'b1, 1'b1, 4'h8));
    vecs.push_back(mk(1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 3, 12'h000, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0));

    drive(mk(1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 0, 12'h000, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0));
    repeat (3) @(posedge iClk);

    foreach (vecs[i]) begin
      @(negedge iClk);
      drive(vecs[i]);
      #1;
      chk("grant", i, 32'(oGrant), 32'(vecs[i].e_gnt));
      chk("mreq",  i, 32'(oMstWrReq), 32'(vecs[i].e_req));
      chk("valid", i, 32'(oMstWrValid), 32'(vecs[i].e_vld));
      chk("last",  i, 32'(oMstWrLast), 32'(vecs[i].e_last));
      chk("ready", i, 32'(oReqWrReady), 32'(vecs[i].e_rdy));
      chk("addr",  i, 32'(oMstWrAddr), vecs[i].e_req ? 32'(vecs[i].addr) : 32'h0);
      chk("sel",   i, 32'(oMstWrSel), vecs[i].e_req ? 32'(vecs[i].src + 1) : 32'h0);
      chk("data",  i, oMstWrData, vecs[i].e_req ? {20'hDA7A0, vecs[i].addr} : 32'h0);
      chk("tmo",   i, 32'(oArbTimeout), 32'h0);
    end

    // Owner 0 stalled by the slave: held forever, or released by the watchdog.
    @(negedge iClk);
    drive(mk(1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 0, 12'h000, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0));
    @(negedge iClk);
    drive(mk(1'b0, 4'h1, 4'h1, 4'h0, 1'b0, 0, 12'h600, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0));
    pulse_at = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge iClk);
      #1;
`ifdef MST_WR_ARB_TIMEOUT_EN
      if (oArbTimeout && (pulse_at < 0)) pulse_at = c;
      if (c <= 17) begin
        chk("wd_grant", 1000 + c, 32'(oGrant), (c == 17) ? 32'h0 : 32'h1);
        chk("wd_tmo", 1000 + c, 32'(oArbTimeout), (c == 17) ? 32'h1 : 32'h0);
      end
`else
      chk("hold_grant", 1000 + c, 32'(oGrant), 32'h1);
      chk("hold_valid", 1000 + c, 32'(oMstWrValid), 32'h1);
      chk("hold_tmo",   1000 + c, 32'(oArbTimeout), 32'h0);
`endif
    end
`ifdef MST_WR_ARB_TIMEOUT_EN
    chk("wd_pulse_cycle", 2000, 32'(pulse_at), 32'd17);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
